// File: rtl/schmidl_cox_preamble_tx.sv
// schmidl_cox_preamble_tx
// Puts a Schmidl & Cox preamble in front of each payload packet. The preamble
// is two identical copies of a programmable half-symbol of length L read from
// a RAM. An optional run of G zero samples follows, then the payload is passed
// through unchanged.
// The output stage is a single register. Preamble RAM reads are prefetched one
// cycle ahead, so the stream has no bubbles while o_tready stays high.
// Optional feature macro: SCHMIDL_COX_TX_GAP_EN builds the zero-sample gap
// (the GAP state, the SR_GAP_LEN register and the G counter).
module schmidl_cox_preamble_tx #(
  parameter int unsigned PRE_AW      = 8,
  parameter logic [7:0]  SR_PRE_LEN  = 8'd129,
  parameter logic [7:0]  SR_GAP_LEN  = 8'd130,
  parameter logic [7:0]  SR_PRE_ADDR = 8'd131,
  parameter logic [7:0]  SR_PRE_DATA = 8'd132
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        sof,
  output logic        busy
);

  localparam logic [PRE_AW:0] L_MAX = {1'b1, {PRE_AW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE_A   = 3'd1,
    PRE_B   = 3'd2,
    GAP     = 3'd3,
    PAYLOAD = 3'd4
  } state_t;

  state_t            state, next_state;
  logic [PRE_AW:0]   pre_len_reg, l_eff, l_sh, l_last, cnt, cnt_plus;
  logic [PRE_AW-1:0] wr_ptr, rd_addr;
  logic [31:0]       ram [2**PRE_AW];
  logic [31:0]       rd_data, emit_data;
  logic              ram_we, adv, emit, emit_last, drain;
  logic              cnt_inc, cnt_clr, first_pending, in_ready;
`ifdef SCHMIDL_COX_TX_GAP_EN
  logic [15:0]       gap_len_reg, g_sh, g_last, gcnt;
  logic              gcnt_inc, gcnt_clr;
`else
  logic              unused_gap_wr;
  assign unused_gap_wr = set_stb && (set_addr == SR_GAP_LEN);
`endif

  // The output register may take a new sample when it is empty or being drained
  assign adv      = !o_tvalid || o_tready;
  assign busy     = (state != IDLE);
  assign i_tready = in_ready;
  assign ram_we   = set_stb && (set_addr == SR_PRE_DATA) && !busy;
  assign l_eff    = (pre_len_reg > L_MAX) ? L_MAX : pre_len_reg;
  assign l_last   = l_sh - (PRE_AW+1)'(1);
  assign cnt_plus = cnt + (PRE_AW+1)'(1);
`ifdef SCHMIDL_COX_TX_GAP_EN
  assign g_last   = g_sh - 16'd1;
`endif

  // Settings registers: half-preamble length and the RAM write pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_len_reg <= '0;
      wr_ptr      <= '0;
    end else if (set_stb) begin
      if (set_addr == SR_PRE_LEN) pre_len_reg <= set_data[PRE_AW:0];
      if (set_addr == SR_PRE_ADDR) wr_ptr <= set_data[PRE_AW-1:0];
      else if (ram_we) wr_ptr <= wr_ptr + PRE_AW'(1);
    end
  end

`ifdef SCHMIDL_COX_TX_GAP_EN
  // Gap length settings register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gap_len_reg <= '0;
    else if (set_stb && (set_addr == SR_GAP_LEN)) gap_len_reg <= set_data[15:0];
  end
`endif

  // Preamble RAM: write from the settings bus, registered read for prefetch; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr] <= set_data;
    rd_data <= ram[rd_addr];
  end

  // Frame shadows track the settings while idle and freeze once a frame starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      l_sh <= '0;
`ifdef SCHMIDL_COX_TX_GAP_EN
      g_sh <= '0;
`endif
    end else if (state == IDLE) begin
      l_sh <= l_eff;
`ifdef SCHMIDL_COX_TX_GAP_EN
      g_sh <= gap_len_reg;
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  end

  // Next-state, sample selection, counter control and RAM prefetch address
  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_data  = '0;
    emit_last  = 1'b0;
    drain      = 1'b0;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    in_ready   = 1'b0;
    rd_addr    = cnt[PRE_AW-1:0];
`ifdef SCHMIDL_COX_TX_GAP_EN
    gcnt_inc   = 1'b0;
    gcnt_clr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        rd_addr = '0;
        drain   = adv;
`ifdef SCHMIDL_COX_TX_GAP_EN
        gcnt_clr = 1'b1;
`endif
        if (i_tvalid) begin
          if (l_eff != '0) next_state = PRE_A;
`ifdef SCHMIDL_COX_TX_GAP_EN
          else if (gap_len_reg != '0) next_state = GAP;
`endif
          else next_state = PAYLOAD;
        end
      end
      PRE_A, PRE_B: begin
        if (adv) begin
          emit      = 1'b1;
          emit_data = rd_data;
          if (cnt == l_last) begin
            cnt_clr = 1'b1;
            rd_addr = '0;
`ifdef SCHMIDL_COX_TX_GAP_EN
            if (state == PRE_A) next_state = PRE_B;
            else if (g_sh != '0) next_state = GAP;
            else next_state = PAYLOAD;
`else
            next_state = (state == PRE_A) ? PRE_B : PAYLOAD;
`endif
          end else begin
            cnt_inc = 1'b1;
            rd_addr = cnt_plus[PRE_AW-1:0];
          end
        end
      end
`ifdef SCHMIDL_COX_TX_GAP_EN
      GAP: begin
        if (adv) begin
          emit = 1'b1;
          if (gcnt == g_last) begin
            gcnt_clr   = 1'b1;
            next_state = PAYLOAD;
          end else begin
            gcnt_inc = 1'b1;
          end
        end
      end
`endif
      PAYLOAD: begin
        in_ready = adv;
        if (adv) begin
          if (i_tvalid) begin
            emit      = 1'b1;
            emit_data = i_tdata;
            emit_last = i_tlast;
            if (i_tlast) next_state = IDLE;
          end else begin
            drain = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Half-preamble sample counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt_plus;
  end

`ifdef SCHMIDL_COX_TX_GAP_EN
  // Gap sample counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) gcnt <= '0;
    else if (gcnt_clr) gcnt <= '0;
    else if (gcnt_inc) gcnt <= gcnt + 16'd1;
  end
`endif

  // Marks that the next emitted sample is the first one of a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) first_pending <= 1'b0;
    else if ((state == IDLE) && (next_state != IDLE)) first_pending <= 1'b1;
    else if (emit) first_pending <= 1'b0;
  end

  // Single output register stage; only changes when it may advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_tvalid <= 1'b0;
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      sof      <= 1'b0;
    end else if (emit) begin
      o_tvalid <= 1'b1;
      o_tdata  <= emit_data;
      o_tlast  <= emit_last;
      sof      <= first_pending;
    end else if (drain) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      sof      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_schmidl_cox_preamble_tx.sv
// tb_schmidl_cox_preamble_tx
// Scoreboard bench: each packet sent pushes its whole expected frame, built from
// a model RAM and model L/G registers, into a queue; a monitor pops and compares
// every accepted output beat and checks that stalled outputs hold stable.
// Honours SCHMIDL_COX_TX_GAP_EN the same way the design does.
module tb_schmidl_cox_preamble_tx;

`ifdef SCHMIDL_COX_TX_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif
  localparam logic [7:0] SR_PRE_LEN  = 8'd129;
  localparam logic [7:0] SR_GAP_LEN  = 8'd130;
  localparam logic [7:0] SR_PRE_ADDR = 8'd131;
  localparam logic [7:0] SR_PRE_DATA = 8'd132;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        last;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        sof;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_cyc      = 0;
  int sof_cyc      = 0;
  int last_cyc     = 0;
  bit rdy_rand     = 1'b0;
  bit allow_idle   = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] m_ram [256];
  int          m_len = 0;
  int          m_gap = 0;
  logic [7:0]  m_ptr = 8'd0;

  schmidl_cox_preamble_tx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_stb  (set_stb),
    .set_addr (set_addr),
    .set_data (set_data),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .sof      (sof),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Settings write; the model follows the register rules, ignoring RAM data while the bench knows a frame is running
  task automatic writeSetting(input logic [7:0] addr, input logic [31:0] data, input bit known_busy);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    @(posedge clk);
    #1;
    set_stb = 1'b0;
    case (addr)
      SR_PRE_LEN:  m_len = int'(data[8:0]);
      SR_GAP_LEN:  m_gap = int'(data[15:0]);
      SR_PRE_ADDR: m_ptr = data[7:0];
      SR_PRE_DATA: if (!known_busy) begin
        m_ram[m_ptr] = data;
        m_ptr = m_ptr + 8'd1;
      end
      default: ;
    endcase
  endtask

  // Reference frame: two copies of RAM[0..L-1], G zeros, then the payload
  task automatic push_frame(input int n, input logic [31:0] pl [16]);
    int l, g;
    bit first;
    exp_t e;
    l = (m_len > 256) ? 256 : m_len;
    g = GAP_EN ? m_gap : 0;
    first = 1'b1;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < l; i++) begin
        e.data = m_ram[i]; e.sof = first; e.last = 1'b0;
        exp_q.push_back(e);
        first = 1'b0;
      end
    for (int i = 0; i < g; i++) begin
      e.data = 32'd0; e.sof = first; e.last = 1'b0;
      exp_q.push_back(e);
      first = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      e.data = pl[k]; e.sof = first; e.last = (k == n - 1);
      exp_q.push_back(e);
      first = 1'b0;
    end
  endtask

  // Sends one random packet of n samples after queueing its expected frame
  task automatic applyStimulus(input int n);
    logic [31:0] pl [16];
    int budget;
    bit got;
    for (int k = 0; k < 16; k++) pl[k] = $urandom;
    push_frame(n, pl);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && allow_idle && $urandom_range(0, 3) == 0) begin
        i_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      i_tdata  = pl[k];
      i_tlast  = (k == n - 1);
      i_tvalid = 1'b1;
      got = 1'b0;
      budget = 0;
      while (!got && budget < 3000) begin
        @(negedge clk);
        if (i_tready) begin
          got = 1'b1;
          if (k == 0) acc_cyc = cyc;
        end else begin
          budget++;
        end
      end
      if (!got) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  // Waits until the scoreboard has consumed every expected beat
  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    #1;
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Output ready driver: always high, or a 50% coin toss per cycle
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      o_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each accepted beat with the scoreboard and checks stall stability
  initial begin
    exp_t e;
    bit stalled;
    logic [31:0] h_data;
    logic h_last, h_sof;
    stalled = 1'b0;
    h_data = '0; h_last = 1'b0; h_sof = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        checkOutput("hold_valid", 32'(o_tvalid), 32'd1);
        checkOutput("hold_data", o_tdata, h_data);
        checkOutput("hold_last", 32'(o_tlast), 32'(h_last));
        checkOutput("hold_sof", 32'(sof), 32'(h_sof));
      end
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", o_tdata, 32'hFFFF_FFFF ^ o_tdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("beat_data", o_tdata, e.data);
          checkOutput("beat_sof", 32'(sof), 32'(e.sof));
          checkOutput("beat_last", 32'(o_tlast), 32'(e.last));
          if (sof) sof_cyc = cyc;
          if (o_tlast) last_cyc = cyc;
        end
      end
      stalled = o_tvalid && !o_tready;
      h_data = o_tdata; h_last = o_tlast; h_sof = sof;
    end
  end

  initial begin
    logic [31:0] pl [16];
    logic [31:0] w;
    int rst_wait;
    reset_n  = 1'b0;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    i_tdata  = '0;
    i_tlast  = 1'b0;
    i_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    checkOutput("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("rst_o_tlast", 32'(o_tlast), 32'd0);
    checkOutput("rst_o_tdata", o_tdata, 32'd0);
    checkOutput("rst_sof", 32'(sof), 32'd0);
    checkOutput("rst_i_tready", 32'(i_tready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Fill the whole RAM (pointer wraps back to 0); RAM[0..3] = 1,2,3,4
    writeSetting(SR_PRE_ADDR, 32'd0, 1'b0);
    for (int i = 0; i < 256; i++)
      writeSetting(SR_PRE_DATA, (i < 4) ? 32'(i + 1) : $urandom, 1'b0);

    // Basic frame, L=4 G=2, no stalls: check content and bubble-free span
    writeSetting(SR_PRE_LEN, 32'd4, 1'b0);
    writeSetting(SR_GAP_LEN, 32'd2, 1'b0);
    applyStimulus(3);
    wait_drain("drain_basic");
    checkOutput("frame_span", 32'(last_cyc - sof_cyc), 32'(2 * 4 + (GAP_EN ? 2 : 0) + 3 - 1));

    // L=0 G=0: payload only, one cycle after acceptance
    writeSetting(SR_PRE_LEN, 32'd0, 1'b0);
    writeSetting(SR_GAP_LEN, 32'd0, 1'b0);
    applyStimulus(1);
    wait_drain("drain_nopre");
    checkOutput("payload_latency", 32'(sof_cyc - acc_cyc), 32'd1);

    // Random backpressure and input bubbles with L=4 G=2
    writeSetting(SR_PRE_LEN, 32'd4, 1'b0);
    writeSetting(SR_GAP_LEN, 32'd2, 1'b0);
    rdy_rand = 1'b1;
    allow_idle = 1'b1;
    applyStimulus(3);
    for (int p = 0; p < 6; p++) applyStimulus($urandom_range(1, 6));
    wait_drain("drain_random");
    rdy_rand = 1'b0;
    allow_idle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // L=6 written mid-frame applies only to the next frame
    fork
      applyStimulus(3);
      begin
        repeat (7) @(posedge clk);
        #1;
        writeSetting(SR_PRE_LEN, 32'd6, 1'b0);
      end
    join
    applyStimulus(2);
    wait_drain("drain_midlen");

    // RAM data write while busy is dropped and the pointer stays put
    writeSetting(SR_PRE_LEN, 32'd4, 1'b0);
    fork
      applyStimulus(2);
      begin
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_mid_frame", 32'(busy), 32'd1);
        writeSetting(SR_PRE_DATA, 32'h0000_DEAD, 1'b1);
      end
    join
    wait_drain("drain_busywr");
    w = $urandom;
    writeSetting(SR_PRE_DATA, w, 1'b0);
    applyStimulus(2);
    wait_drain("drain_ptr");

    // Over-range L is clamped to the RAM depth
    writeSetting(SR_PRE_LEN, 32'd300, 1'b0);
    applyStimulus(2);
    wait_drain("drain_clamp");

    // Reset in the middle of a frame (GAP, or PRE_B without the gap build)
    writeSetting(SR_PRE_LEN, 32'd4, 1'b0);
    writeSetting(SR_GAP_LEN, 32'd2, 1'b0);
    rst_wait = GAP_EN ? 10 : 8;
    for (int k = 0; k < 16; k++) pl[k] = $urandom;
    push_frame(1, pl);
    i_tdata  = pl[0];
    i_tlast  = 1'b1;
    i_tvalid = 1'b1;
    repeat (rst_wait) @(posedge clk);
    #1;
    checkOutput("pre_reset_i_tready", 32'(i_tready), 32'd0);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_o_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("mid_rst_o_tlast", 32'(o_tlast), 32'd0);
    checkOutput("mid_rst_o_tdata", o_tdata, 32'd0);
    checkOutput("mid_rst_sof", 32'(sof), 32'd0);
    checkOutput("mid_rst_i_tready", 32'(i_tready), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    exp_q.delete();
    m_len = 0;
    m_gap = 0;
    m_ptr = 8'd0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    writeSetting(SR_PRE_LEN, 32'd4, 1'b0);
    writeSetting(SR_GAP_LEN, 32'd2, 1'b0);
    applyStimulus(3);
    wait_drain("drain_after_reset");

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
